// File: rtl/host_step_pkg.sv
// Shared encodings for host_step_ctrl: FSM states, pacing phases and status word layout.
package host_step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BREAK = 2'd3
    } state_e;

    typedef enum logic {
        PH_EN     = 1'b0,
        PH_SETTLE = 1'b1
    } phase_e;

    localparam int STAT_HALTED   = 0;
    localparam int STAT_BUSY     = 1;
    localparam int STAT_BP_HIT   = 2;
    localparam int STAT_STATE_LO = 3;
    localparam int STAT_REM_LO   = 16;

    function automatic logic [31:0] pack_status(
        input logic [15:0] rem,
        input state_e      st,
        input logic        bp_hit,
        input logic        busy,
        input logic        halted
    );
        logic [31:0] w;
        w = '0;
        w[STAT_REM_LO +: 16]  = rem;
        w[STAT_STATE_LO +: 2] = st;
        w[STAT_BP_HIT]        = bp_hit;
        w[STAT_BUSY]          = busy;
        w[STAT_HALTED]        = halted;
        return w;
    endfunction

endpackage

// File: rtl/pc_trace_buf.sv
// Circular PC history; read index 0 returns the most recently written entry.
module pc_trace_buf #(
    parameter  int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_data_o
);

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] wptr_q;
    logic [IDX_W-1:0] rd_addr;

    // Power-of-two depth lets the pointer arithmetic wrap for free.
    assign rd_addr   = wptr_q - IDX_W'(1) - rd_idx_i;
    assign rd_data_o = mem_q[rd_addr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
        end else if (we_i) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= wptr_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/host_step_ctrl.sv
// Host run/step requests -> paced single-cycle core clock enable with N-step bursts and PC breakpoint.
// Optional PC trace buffer is compiled in with HOST_STEP_TRACE_EN.
module host_step_ctrl
    import host_step_pkg::*;
#(
    parameter int STEP_W      = 16,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                           sysclk,
    input  logic                           rst,
    input  logic                           ctrl_run,
    input  logic                           ctrl_step,
    input  logic [STEP_W-1:0]              step_count,
    input  logic                           bp_en,
    input  logic [31:0]                    bp_addr,
    input  logic [31:0]                    mips_pc_current,
    output logic                           core_clk_en,
    output logic                           halted,
    output logic                           busy,
    output logic                           bp_hit,
    output logic [31:0]                    cycle_count,
    output logic [31:0]                    status,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [31:0]                    trace_pc
);

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              step_prev_q;
    logic              core_clk_en_q, core_clk_en_d;
    logic              halted_q, halted_d;
    logic              busy_q, busy_d;
    logic              bp_hit_q, bp_hit_d;
    logic [31:0]       cycle_count_q, cycle_count_d;

    logic              step_edge;
    logic              pc_match;
    logic [STEP_W-1:0] rem_load;
    logic [STEP_W-1:0] rem_dec;
    logic [15:0]       rem16;

    assign step_edge = ctrl_step & ~step_prev_q;
    assign pc_match  = bp_en && (mips_pc_current == bp_addr);
    assign rem_load  = (step_count == '0) ? STEP_W'(1) : step_count;
    assign rem_dec   = rem_q - STEP_W'(1);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            phase_q       <= PH_EN;
            rem_q         <= '0;
            step_prev_q   <= 1'b0;
            core_clk_en_q <= 1'b0;
            halted_q      <= 1'b1;
            busy_q        <= 1'b0;
            bp_hit_q      <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            rem_q         <= rem_d;
            step_prev_q   <= ctrl_step;
            core_clk_en_q <= core_clk_en_d;
            halted_q      <= halted_d;
            busy_q        <= busy_d;
            bp_hit_q      <= bp_hit_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // The PC compare only runs in SETTLE, i.e. after an issued enable, so a resume always advances.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_run) begin
                    state_d = ST_RUN;
                    phase_d = PH_EN;
                end else if (step_edge) begin
                    state_d = ST_STEP;
                    phase_d = PH_EN;
                    rem_d   = rem_load;
                end
            end
            ST_STEP: begin
                if (phase_q == PH_EN) begin
                    phase_d = PH_SETTLE;
                end else begin
                    rem_d   = rem_dec;
                    phase_d = PH_EN;
                    if (pc_match) begin
                        state_d = ST_BREAK;
                    end else if (rem_dec == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (phase_q == PH_EN) begin
                    phase_d = PH_SETTLE;
                end else begin
                    phase_d = PH_EN;
                    if (pc_match) begin
                        state_d = ST_BREAK;
                    end else if (!ctrl_run) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (step_edge) begin
                    state_d = ST_STEP;
                    phase_d = PH_EN;
                    rem_d   = rem_load;
                end else if (!ctrl_run) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = PH_EN;
            end
        endcase
    end

    always_comb begin
        core_clk_en_d = ((state_d == ST_STEP) || (state_d == ST_RUN)) && (phase_d == PH_EN);
        halted_d      = (state_d == ST_IDLE) || (state_d == ST_BREAK);
        busy_d        = (state_d == ST_STEP) || (state_d == ST_RUN);
        bp_hit_d      = (state_d == ST_BREAK);
        cycle_count_d = cycle_count_q + (core_clk_en_q ? 32'd1 : 32'd0);
    end

    generate
        if (STEP_W >= 16) begin : g_rem_trunc
            assign rem16 = rem_q[15:0];
        end else begin : g_rem_ext
            assign rem16 = {{(16 - STEP_W){1'b0}}, rem_q};
        end
    endgenerate

    assign core_clk_en = core_clk_en_q;
    assign halted      = halted_q;
    assign busy        = busy_q;
    assign bp_hit      = bp_hit_q;
    assign cycle_count = cycle_count_q;
    assign status      = pack_status(rem16, state_q, bp_hit_q, busy_q, halted_q);

`ifdef HOST_STEP_TRACE_EN
    logic trace_we;

    assign trace_we = ((state_q == ST_STEP) || (state_q == ST_RUN)) && (phase_q == PH_SETTLE);

    pc_trace_buf #(
        .DEPTH(TRACE_DEPTH)
    ) u_trace (
        .clk_i    (sysclk),
        .rst_i    (rst),
        .we_i     (trace_we),
        .wdata_i  (mips_pc_current),
        .rd_idx_i (trace_idx),
        .rd_data_o(trace_pc)
    );
`else
    logic unused_trace_idx;

    assign unused_trace_idx = ^trace_idx;
    assign trace_pc         = '0;
`endif

endmodule

// File: doc/host_step_ctrl.md
Name: host_step_ctrl

Overview:
- Host-driven clock-enable controller sitting directly upstream of the MIPS core inside fpga_top.
- Converts AXI control-register levels (run, step) into a paced, single-cycle core clock enable.
- Supports N-cycle stepping and a PC breakpoint.
- Exports a packed status word and an enabled-cycle counter for the spare AXI output registers (reg7 and similar).

Parameters:
- STEP_W, 16, width of the step_count input and of the remaining-steps counter
- TRACE_DEPTH, 8, PC trace buffer depth; power of two; used only when the optional feature is compiled in

Ports:
- sysclk  in  1  single system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- ctrl_run  in  1  level; high requests free run
- ctrl_step  in  1  rising edge requests one step burst
- step_count  in  STEP_W  core cycles per step burst; 0 is treated as 1
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- mips_pc_current  in  32  core PC, registered in the core on the enabled sysclk edge
- core_clk_en  out  1  registered one-cycle enable to the core
- halted  out  1  high in IDLE or BREAK
- busy  out  1  high in STEP or RUN
- bp_hit  out  1  high while in BREAK
- cycle_count  out  32  count of issued core_clk_en pulses
- status  out  32  {rem[15:0], 11'b0, state[1:0], bp_hit, busy, halted}; rem is zero-extended or truncated to 16 bits
- trace_idx  in  $clog2(TRACE_DEPTH)  trace read index; 0 = most recent
- trace_pc  out  32  traced PC

Behaviour:
- One clock (sysclk); reset is synchronous and active-high on rst. No other clock domains.
- Reset values: state=IDLE, phase=0, core_clk_en=0, halted=1, busy=0, bp_hit=0, cycle_count=0, rem=0, step_prev=0.
- Reset mid-burst aborts immediately; no further enable is issued.
- Step edge: step_prev is registered ctrl_step; edge = ctrl_step & ~step_prev.
- Pacing: STEP and RUN alternate two phases.
  - EN phase: core_clk_en=1 for exactly one sysclk cycle.
  - SETTLE phase: core_clk_en=0; mips_pc_current is valid and compared.
  - Maximum rate is one core cycle per 2 sysclk cycles.
- State IDLE:
  - ctrl_run=1 -> RUN; an edge in the same cycle is discarded.
  - Otherwise edge -> STEP, with rem = (step_count==0) ? 1 : step_count.
  - The first EN occurs in the cycle after entry.
- State STEP:
  - At each SETTLE, rem decrements.
  - If bp_en && pc==bp_addr -> BREAK. Breakpoint has priority over rem==0.
  - Else if rem reaches 0 -> IDLE.
  - Step edges and ctrl_run are ignored while in STEP.
- State RUN:
  - At SETTLE, breakpoint match -> BREAK.
  - Else ctrl_run==0 -> IDLE.
  - ctrl_run falling during EN takes effect at that burst's SETTLE; the in-flight enable always completes.
- State BREAK:
  - bp_hit=1.
  - Edge -> STEP (run is ignored); rem reloads from step_count.
  - Else ctrl_run==0 -> IDLE.
  - ctrl_run held high keeps the block in BREAK; the host must drop and re-raise run to resume.
  - The compare happens only after an issued enable, so resuming from the breakpoint PC always advances.
- Counters:
  - cycle_count increments on every core_clk_en and wraps from 0xFFFFFFFF to 0.
  - Compare is full 32-bit equality.
- halted and busy are registered and consistent with state in the same cycle.

Optional Feature:
- Macro: HOST_STEP_TRACE_EN.
- When defined:
  - A TRACE_DEPTH circular buffer records mips_pc_current at every SETTLE.
  - The write pointer wraps at TRACE_DEPTH.
  - trace_pc = entry (wptr-1-trace_idx) mod TRACE_DEPTH, read combinationally.
  - Entries reset to 0.
- When not defined: trace_pc is tied to 0 and no storage is inferred.

Decomposition:
- Package host_step_pkg:
  - State encoding IDLE=0, STEP=1, RUN=2, BREAK=3.
  - Status bit positions.
  - Phase constants.
- One sub-module, pc_trace_buf (circular buffer plus index read), instantiated only under HOST_STEP_TRACE_EN.

Test Plan:
- Reset, then idle 10 cycles -> core_clk_en never high, halted=1, status=0x00000001, cycle_count=0.
- step_count=3, pulse ctrl_step -> exactly 3 enables spaced 2 cycles apart, cycle_count=3, return to IDLE, halted=1.
- step_count=0, pulse ctrl_step -> exactly 1 enable; a second edge asserted mid-burst with step_count=5 is ignored.
- Core PC increments by 4 from 0, bp_en=1, bp_addr=0x10, ctrl_run=1 -> 4 enables, BREAK, bp_hit=1, state field=3, no 5th enable. Then pulse ctrl_step with step_count=1 -> one enable, PC=0x14, IDLE.
- RUN, drop ctrl_run during EN -> the enable completes, IDLE at SETTLE. ctrl_run and step edge in the same cycle from IDLE -> RUN, edge discarded.
- Assert rst mid-RUN -> next cycle all outputs at reset values. With HOST_STEP_TRACE_EN, after 10 steps trace_idx=0 returns the latest PC and trace_idx=7 returns the PC 7 steps earlier.
